// File: rtl/nand_logic_unit_pipe_if.sv
// Handshake bundle for nand_logic_unit_pipe.
// Producer side: in_valid/in_ready with operands A, B, op, in_chain.
// Consumer side: out_valid/out_ready with result Y.
// master = the environment driving operands and taking results; slave = the logic unit.
interface nand_logic_unit_pipe_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             in_chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;

    modport master (
        output in_valid, A, B, op, in_chain, out_ready,
        input  in_ready, out_valid, Y
    );

    modport slave (
        input  in_valid, A, B, op, in_chain, out_ready,
        output in_ready, out_valid, Y
    );
endinterface

// File: rtl/nand_logic_unit_pipe.sv
// nand_logic_unit_pipe: registered WIDTH-bit bitwise logic unit (8 ops, NAND at op=000)
// with valid/ready on both sides and a 2-entry result FIFO.
// Optional build macro NAND_LU_CNT_EN adds the 16-bit accepted-operation counter txn_cnt.
// in_ready depends only on the registered fill count, so a full buffer never
// accepts in the same cycle it pops; the slot frees up one cycle later.
module nand_logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nand_logic_unit_pipe_if.slave bus
`ifdef NAND_LU_CNT_EN
    ,
    output logic [15:0]           txn_cnt
`endif
);

    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("nand_logic_unit_pipe: DEPTH must be 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("nand_logic_unit_pipe: WIDTH must be >= 1");
        end
    endgenerate

    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [WIDTH-1:0] mem [0:1];
    logic [WIDTH-1:0] last_res;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             pop;

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.Y         = bus.out_valid ? mem[rd_ptr] : '0;

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;

    // Operand select and bitwise operation on the incoming operand set
    always_comb begin
        operand_b = bus.in_chain ? last_res : bus.B;
        result    = '0;
        case (bus.op)
            3'b000:  result = ~(bus.A & operand_b);
            3'b001:  result =   bus.A & operand_b;
            3'b010:  result =   bus.A | operand_b;
            3'b011:  result = ~(bus.A | operand_b);
            3'b100:  result =   bus.A ^ operand_b;
            3'b101:  result = ~(bus.A ^ operand_b);
            3'b110:  result = ~bus.A;
            default: result =   bus.A;
        endcase
    end

    // Result FIFO, pointers, fill count and chaining register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            last_res <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= ~wr_ptr;
                last_res    <= result;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef NAND_LU_CNT_EN
    // Accepted-operation counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= 16'd0;
        end else if (accept) begin
            txn_cnt <= txn_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nand_logic_unit_pipe.sv
// Directed bench for nand_logic_unit_pipe (WIDTH=4): vector table for the
// single-cycle ops and chaining, hand sequences for backpressure and reset.
// Counter checks only exist when NAND_LU_CNT_EN is defined.
module tb_nand_logic_unit_pipe;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
`ifdef NAND_LU_CNT_EN
    logic [15:0] txn_cnt;
`endif

    nand_logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

    nand_logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
`ifdef NAND_LU_CNT_EN
        ,
        .txn_cnt (txn_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       chain;
        logic [3:0] y;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic chain);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.A        = a;
        bus.B        = b;
        bus.in_chain = chain;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8 && bus.out_valid === 1'b1; k++) @(negedge clk);
        check("drain_timeout", {15'd0, bus.out_valid}, 16'd0);
    endtask

    initial begin
        // op, A, B, chain, expected Y
        vecs[0]  = '{3'b000, 4'b0010, 4'b1000, 1'b0, 4'b1111};
        vecs[1]  = '{3'b000, 4'b0011, 4'b0100, 1'b0, 4'b1111};
        vecs[2]  = '{3'b000, 4'b1100, 4'b1100, 1'b0, 4'b0011};
        vecs[3]  = '{3'b000, 4'b1100, 4'b1010, 1'b0, 4'b0111};
        vecs[4]  = '{3'b001, 4'b1100, 4'b1010, 1'b0, 4'b1000};
        vecs[5]  = '{3'b010, 4'b1100, 4'b1010, 1'b0, 4'b1110};
        vecs[6]  = '{3'b011, 4'b1100, 4'b1010, 1'b0, 4'b0001};
        vecs[7]  = '{3'b100, 4'b1100, 4'b1010, 1'b0, 4'b0110};
        vecs[8]  = '{3'b101, 4'b1100, 4'b1010, 1'b0, 4'b1001};
        vecs[9]  = '{3'b110, 4'b1100, 4'b1010, 1'b0, 4'b0011};
        vecs[10] = '{3'b111, 4'b1100, 4'b1010, 1'b0, 4'b1100};
        vecs[11] = '{3'b000, 4'b1111, 4'b0000, 1'b0, 4'b1111};
        vecs[12] = '{3'b001, 4'b0101, 4'b0000, 1'b1, 4'b0101};
        vecs[13] = '{3'b100, 4'b1111, 4'b0000, 1'b1, 4'b1010};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.op        = 3'b000;
        bus.in_chain  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_y",         {12'd0, bus.Y},         16'd0);
        check("rst_in_ready",  {15'd0, bus.in_ready},  16'd1);

        // Table: one accept per cycle, result visible the cycle after accept
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain);
            check($sformatf("vec%0d_in_ready", i), {15'd0, bus.in_ready}, 16'd1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), {15'd0, bus.out_valid}, 16'd1);
            check($sformatf("vec%0d_y", i), {12'd0, bus.Y}, {12'd0, vecs[i].y});
        end

        // Backpressure: two results queue, third offer stalls, then drains in order
        @(negedge clk);
        drain();
        bus.out_ready = 1'b0;
        drive(3'b000, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        drive(3'b111, 4'b0101, 4'b0000, 1'b0);
        @(negedge clk);
        drive(3'b110, 4'b1001, 4'b0000, 1'b0);
        check("bp_in_ready_full", {15'd0, bus.in_ready},  16'd0);
        check("bp_out_valid",     {15'd0, bus.out_valid}, 16'd1);
        check("bp_head_y",        {12'd0, bus.Y},         16'h000f);
        repeat (3) @(negedge clk);
        check("bp_y_stable",      {12'd0, bus.Y},         16'h000f);
        check("bp_still_full",    {15'd0, bus.in_ready},  16'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_pop1_y",        {12'd0, bus.Y},         16'h0005);
        check("bp_pop1_ready",    {15'd0, bus.in_ready},  16'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_third_y",       {12'd0, bus.Y},         16'h0006);
        check("bp_third_valid",   {15'd0, bus.out_valid}, 16'd1);
        @(posedge clk);
        #1;
        check("bp_empty",         {15'd0, bus.out_valid}, 16'd0);

        // Reset with a full buffer and a nonzero last_res
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(3'b000, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        drive(3'b111, 4'b0101, 4'b0000, 1'b0);
        @(negedge clk);
        check("rs_full", {15'd0, bus.in_ready}, 16'd0);
        rst_n = 1'b0;
        #1;
        check("rs_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rs_y",         {12'd0, bus.Y},         16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rs_in_ready_after",  {15'd0, bus.in_ready},  16'd1);
        check("rs_out_valid_after", {15'd0, bus.out_valid}, 16'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(3'b101, 4'b0011, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rs_chain_zero", {12'd0, bus.Y}, 16'h000c);

`ifdef NAND_LU_CNT_EN
        // Counter: five accepts with one stalled offer, then the 16-bit wrap
        @(negedge clk);
        drain();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("cnt_reset", txn_cnt, 16'd0);
        bus.out_ready = 1'b0;
        drive(3'b000, 4'b0001, 4'b0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("cnt_stalled", txn_cnt, 16'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 4 && bus.in_ready !== 1'b1; t++) @(negedge clk);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("cnt_five", txn_cnt, 16'd5);
        drain();
        drive(3'b000, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < 65530; k++) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("cnt_ffff", txn_cnt, 16'hffff);
        @(negedge clk);
        drive(3'b000, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("cnt_wrap", txn_cnt, 16'h0000);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
